// File: rtl/if_id_buffer_pkg.sv
// Shared IF/ID constants and state encoding; pure definitions, no logic.
// Imported by the IF/ID buffer top and its slot entries.
package mips_if_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int          PC_INC   = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_t;

endpackage

// File: rtl/if_id_buffer_slot.sv
// One IF/ID entry (valid, pc_plus4, instr); loads in 1 cycle, clear wins over load.
// No backpressure of its own: the owning FSM decides when to load or clear.
module if_id_slot #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_load,
    input  logic                   i_clear,
    input  logic [PC_WIDTH-1:0]    i_pc_plus4,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    output logic                   o_valid,
    output logic [PC_WIDTH-1:0]    o_pc_plus4,
    output logic [INSTR_WIDTH-1:0] o_instr
);

    logic                   r_valid;
    logic [PC_WIDTH-1:0]    r_pc_plus4;
    logic [INSTR_WIDTH-1:0] r_instr;

    // Clear only drops valid; stale data is masked downstream by the valid bit.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_valid    <= 1'b0;
            r_pc_plus4 <= '0;
            r_instr    <= '0;
        end else if (i_clear) begin
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_pc_plus4 <= i_pc_plus4;
            r_instr    <= i_instr;
        end
    end

    assign o_valid    = r_valid;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_instr    = r_instr;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID stage with main/skid entries; 1-cycle latency, absorbs the one in-flight read on stall.
// Optional IF_ID_PERF_CNT_EN adds saturating stall/flush counters (ports tied to 0 otherwise).
module if_id_buffer
    import mips_if_pkg::*;
#(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = mips_if_pkg::NOP_WORD
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic [PC_WIDTH-1:0]    i_pc,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic                   i_instr_valid,
    output logic                   o_pc_write,
    output logic                   o_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [PC_WIDTH-1:0]    o_pc_plus4,
    output logic                   o_skid_full,
    output logic [15:0]            o_stall_cnt,
    output logic [15:0]            o_flush_cnt
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_m_load, w_m_clear, w_m_from_s;
    logic                   w_s_load, w_s_clear;
    logic [PC_WIDTH-1:0]    w_in_pc4;
    logic [PC_WIDTH-1:0]    w_m_pc4_d;
    logic [INSTR_WIDTH-1:0] w_m_instr_d;
    logic                   w_m_valid, w_s_valid;
    logic [PC_WIDTH-1:0]    w_m_pc4, w_s_pc4;
    logic [INSTR_WIDTH-1:0] w_m_instr, w_s_instr;

    assign w_in_pc4    = i_pc + PC_WIDTH'(PC_INC);
    assign w_m_pc4_d   = w_m_from_s ? w_s_pc4   : w_in_pc4;
    assign w_m_instr_d = w_m_from_s ? w_s_instr : i_instr;

    always_comb begin
        w_state_nxt = r_state;
        w_m_load    = 1'b0;
        w_m_clear   = 1'b0;
        w_m_from_s  = 1'b0;
        w_s_load    = 1'b0;
        w_s_clear   = 1'b0;
        if (i_enable) begin
            if (i_flush) begin
                w_m_clear   = 1'b1;
                w_s_clear   = 1'b1;
                w_state_nxt = EMPTY;
            end else begin
                case (r_state)
                    EMPTY: if (i_instr_valid) begin
                        w_m_load    = 1'b1;
                        w_state_nxt = ONE;
                    end
                    ONE: begin
                        if (!i_stall && i_instr_valid) begin
                            w_m_load = 1'b1;
                        end else if (!i_stall) begin
                            w_m_clear   = 1'b1;
                            w_state_nxt = EMPTY;
                        end else if (i_instr_valid) begin
                            w_s_load    = 1'b1;
                            w_state_nxt = TWO;
                        end
                    end
                    TWO: if (!i_stall) begin
                        w_m_load    = 1'b1;
                        w_m_from_s  = 1'b1;
                        w_s_clear   = 1'b1;
                        w_state_nxt = ONE;
                    end
                    default: w_state_nxt = EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    if_id_slot #(.PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) u_main (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_m_load),
        .i_clear    (w_m_clear),
        .i_pc_plus4 (w_m_pc4_d),
        .i_instr    (w_m_instr_d),
        .o_valid    (w_m_valid),
        .o_pc_plus4 (w_m_pc4),
        .o_instr    (w_m_instr)
    );

    if_id_slot #(.PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) u_skid (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_s_load),
        .i_clear    (w_s_clear),
        .i_pc_plus4 (w_in_pc4),
        .i_instr    (i_instr),
        .o_valid    (w_s_valid),
        .o_pc_plus4 (w_s_pc4),
        .o_instr    (w_s_instr)
    );

    // A flush must let the PC load the branch target even while the buffer is full.
    assign o_pc_write  = i_enable & (i_flush |
                         ((r_state != TWO) & ~((r_state == ONE) & i_stall)));
    assign o_valid     = w_m_valid;
    assign o_instr     = w_m_valid ? w_m_instr : NOP_WORD;
    assign o_pc_plus4  = w_m_pc4;
    assign o_skid_full = w_s_valid;

`ifdef IF_ID_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (i_enable && i_stall && w_m_valid && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (i_enable && i_flush && (r_flush_cnt != 16'hFFFF))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`else
    assign o_stall_cnt = 16'd0;
    assign o_flush_cnt = 16'd0;
`endif

    // With both entries full a new fetch has nowhere to go unless it is being flushed.
    a_no_fetch_when_full: assert property (@(posedge i_clk) disable iff (!i_reset)
        (i_enable && !i_flush && r_state == TWO) |-> !i_instr_valid);

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed scenarios plus a randomized back-to-back run.
module tb_if_id_buffer;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_stall;
    logic        i_flush;
    logic [31:0] i_pc;
    logic [31:0] i_instr;
    logic        i_instr_valid;
    logic        o_pc_write;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc_plus4;
    logic        o_skid_full;
    logic [15:0] o_stall_cnt;
    logic [15:0] o_flush_cnt;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] ins;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic last_pcw;

    always #5 i_clk = ~i_clk;

    if_id_buffer dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_stall       (i_stall),
        .i_flush       (i_flush),
        .i_pc          (i_pc),
        .i_instr       (i_instr),
        .i_instr_valid (i_instr_valid),
        .o_pc_write    (o_pc_write),
        .o_valid       (o_valid),
        .o_instr       (o_instr),
        .o_pc_plus4    (o_pc_plus4),
        .o_skid_full   (o_skid_full),
        .o_stall_cnt   (o_stall_cnt),
        .o_flush_cnt   (o_flush_cnt)
    );

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return {8'h8C, pc[23:0]};
    endfunction

    // One clock: apply inputs, sample the PC strobe, update the scoreboard at the edge.
    task automatic drive(input logic en, input logic st, input logic fl,
                         input logic v, input logic [31:0] pc);
        logic consume, accept;
        exp_t e;
        i_enable      = en;
        i_stall       = st;
        i_flush       = fl;
        i_instr_valid = v;
        i_pc          = pc;
        i_instr       = ins_of(pc);
        #1;
        last_pcw = o_pc_write;
        consume  = en && !fl && !st && o_valid;
        accept   = en && !fl && v;
        e.pc4    = pc + 32'd4;
        e.ins    = ins_of(pc);
        @(posedge i_clk);
        if (en && fl) begin
            exp_q.delete();
        end else begin
            if (consume && exp_q.size() != 0) void'(exp_q.pop_front());
            if (accept) exp_q.push_back(e);
        end
        #1;
        i_instr_valid = 1'b0;
        i_flush       = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_enable = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
        i_instr_valid = 1'b0; i_pc = '0; i_instr = '0;
        #12;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_checks++; if (o_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", o_instr); end
        n_checks++; if (o_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h want 0", o_pc_plus4); end
        n_checks++; if (o_skid_full !== 1'b0) begin n_fail++; $display("FAIL reset_skid: got %b want 0", o_skid_full); end
        n_checks++; if (o_stall_cnt !== 16'd0 || o_flush_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", o_stall_cnt, o_flush_cnt); end
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        #1;
        n_checks++; if (o_pc_write !== 1'b1) begin n_fail++; $display("FAIL reset_pcw: got %b want 1", o_pc_write); end
        exp_q.delete();
    endtask

    task automatic test_stream();
        drive(1, 0, 0, 1, 32'd100);
        n_checks++; if (o_valid !== 1'b1 || o_pc_plus4 !== 32'd104) begin
            n_fail++; $display("FAIL stream_first: got v=%b pc4=%0d want v=1 pc4=104", o_valid, o_pc_plus4); end
        n_checks++; if (exp_q.size() == 0 || o_instr !== exp_q[0].ins) begin
            n_fail++; $display("FAIL stream_first_instr: got %h want %h", o_instr, ins_of(32'd100)); end
        drive(1, 0, 0, 1, 32'd104);
        n_checks++; if (last_pcw !== 1'b1) begin n_fail++; $display("FAIL stream_pcw: got %b want 1", last_pcw); end
        n_checks++; if (exp_q.size() == 0 || o_pc_plus4 !== exp_q[0].pc4 || o_pc_plus4 !== 32'd108) begin
            n_fail++; $display("FAIL stream_second: got pc4=%0d want 108", o_pc_plus4); end
        drive(1, 0, 0, 0, 32'd0);
        n_checks++; if (o_valid !== 1'b0 || o_instr !== 32'h0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL stream_drain: got v=%b instr=%h want v=0 instr=0", o_valid, o_instr); end
    endtask

    task automatic test_stall();
        drive(1, 0, 0, 1, 32'd200);
        drive(1, 1, 0, 1, 32'd204);
        n_checks++; if (last_pcw !== 1'b0) begin n_fail++; $display("FAIL stall_pcw_one: got %b want 0", last_pcw); end
        n_checks++; if (o_skid_full !== 1'b1 || o_pc_plus4 !== 32'd204) begin
            n_fail++; $display("FAIL stall_skid: got skid=%b pc4=%0d want skid=1 pc4=204", o_skid_full, o_pc_plus4); end
        drive(1, 1, 0, 0, 32'd0);
        n_checks++; if (last_pcw !== 1'b0 || o_pc_plus4 !== 32'd204 || o_skid_full !== 1'b1) begin
            n_fail++; $display("FAIL stall_hold: got pcw=%b pc4=%0d skid=%b want 0/204/1", last_pcw, o_pc_plus4, o_skid_full); end
        drive(1, 0, 0, 0, 32'd0);
        n_checks++; if (last_pcw !== 1'b0) begin n_fail++; $display("FAIL stall_pcw_two: got %b want 0", last_pcw); end
        n_checks++; if (o_pc_plus4 !== 32'd208 || o_skid_full !== 1'b0 || exp_q.size() == 0 || o_instr !== exp_q[0].ins) begin
            n_fail++; $display("FAIL stall_release: got pc4=%0d skid=%b instr=%h want 208/0/%h", o_pc_plus4, o_skid_full, o_instr, ins_of(32'd204)); end
        drive(1, 0, 0, 0, 32'd0);
        n_checks++; if (last_pcw !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_drain: got pcw=%b v=%b want 1/0", last_pcw, o_valid); end
    endtask

    task automatic test_flush();
        drive(1, 0, 0, 1, 32'd292);
        drive(1, 1, 0, 1, 32'd296);
        drive(1, 1, 1, 1, 32'd300);
        n_checks++; if (last_pcw !== 1'b1) begin n_fail++; $display("FAIL flush_pcw: got %b want 1", last_pcw); end
        n_checks++; if (o_valid !== 1'b0 || o_instr !== 32'h0 || o_skid_full !== 1'b0) begin
            n_fail++; $display("FAIL flush_out: got v=%b instr=%h skid=%b want 0/0/0", o_valid, o_instr, o_skid_full); end
        drive(1, 0, 0, 0, 32'd0);
        n_checks++; if (last_pcw !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_empty: got pcw=%b v=%b want 1/0", last_pcw, o_valid); end
    endtask

    task automatic test_enable();
        drive(1, 0, 0, 1, 32'd380);
        drive(0, 0, 1, 1, 32'd400);
        n_checks++; if (last_pcw !== 1'b0) begin n_fail++; $display("FAIL enable_pcw: got %b want 0", last_pcw); end
        n_checks++; if (o_valid !== 1'b1 || o_pc_plus4 !== 32'd384 || o_instr !== ins_of(32'd380)) begin
            n_fail++; $display("FAIL enable_hold: got v=%b pc4=%0d want 1/384", o_valid, o_pc_plus4); end
        drive(0, 0, 0, 0, 32'd0);
        n_checks++; if (o_valid !== 1'b1 || o_pc_plus4 !== 32'd384) begin
            n_fail++; $display("FAIL enable_hold2: got v=%b pc4=%0d want 1/384", o_valid, o_pc_plus4); end
        drive(1, 0, 0, 1, 32'd404);
        n_checks++; if (last_pcw !== 1'b1 || o_pc_plus4 !== 32'd408 || exp_q.size() == 0 || o_pc_plus4 !== exp_q[0].pc4) begin
            n_fail++; $display("FAIL enable_resume: got pcw=%b pc4=%0d want 1/408", last_pcw, o_pc_plus4); end
        drive(1, 0, 0, 0, 32'd0);
    endtask

    task automatic test_wrap();
        drive(1, 0, 0, 1, 32'hFFFF_FFFC);
        n_checks++; if (o_valid !== 1'b1 || o_pc_plus4 !== 32'h0 || exp_q.size() == 0 || o_pc_plus4 !== exp_q[0].pc4) begin
            n_fail++; $display("FAIL wrap: got v=%b pc4=%h want 1/00000000", o_valid, o_pc_plus4); end
        drive(1, 0, 0, 0, 32'd0);
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 1, 32'd500);
        drive(1, 1, 0, 1, 32'd504);
        i_stall = 1'b1;
        #3;
        i_reset = 1'b0;
        #1;
        n_checks++; if (o_valid !== 1'b0 || o_instr !== 32'h0 || o_skid_full !== 1'b0 || o_pc_plus4 !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid: got v=%b instr=%h skid=%b pc4=%h want all 0", o_valid, o_instr, o_skid_full, o_pc_plus4); end
        exp_q.delete();
        @(posedge i_clk); #1;
        i_reset = 1'b1; i_stall = 1'b0; i_enable = 1'b1;
        #1;
        n_checks++; if (o_pc_write !== 1'b1) begin n_fail++; $display("FAIL reset_mid_pcw: got %b want 1", o_pc_write); end
        drive(1, 0, 0, 1, 32'd508);
        n_checks++; if (o_valid !== 1'b1 || o_pc_plus4 !== 32'd512) begin
            n_fail++; $display("FAIL reset_mid_resume: got v=%b pc4=%0d want 1/512", o_valid, o_pc_plus4); end
        drive(1, 0, 0, 0, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc;
        logic        st, fl, v, exp_pcw;
        int          sz;
        pc = 32'h0000_1000;
        for (int i = 0; i < 300; i++) begin
            sz = exp_q.size();
            n_checks++; if (o_valid !== (sz != 0) || o_skid_full !== (sz == 2)) begin
                n_fail++; $display("FAIL b2b_occ[%0d]: got v=%b skid=%b want entries=%0d", i, o_valid, o_skid_full, sz); end
            if (sz != 0) begin
                n_checks++; if (o_pc_plus4 !== exp_q[0].pc4 || o_instr !== exp_q[0].ins) begin
                    n_fail++; $display("FAIL b2b_data[%0d]: got pc4=%h instr=%h want %h/%h", i, o_pc_plus4, o_instr, exp_q[0].pc4, exp_q[0].ins); end
            end
            st = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 15) == 0);
            v  = (sz != 2) && ($urandom_range(0, 3) != 0);
            exp_pcw = fl || ((sz != 2) && !((sz == 1) && st));
            drive(1, st, fl, v, pc);
            n_checks++; if (last_pcw !== exp_pcw) begin
                n_fail++; $display("FAIL b2b_pcw[%0d]: got %b want %b", i, last_pcw, exp_pcw); end
            if (v) pc = pc + 32'd4;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_enable();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
